mux_share_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 2-to-1 mux datapath (x/y -> m) between two

---
 rtl/mux_share_arbiter.sv | 90 +++++++++
 tb/tb_mux_share_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux select. Grant follows req by one cycle and m lags the owner's data by one cycle.
// A waiting requester preempts the owner after HOLD_MAX cycles; with no competitor the tenure is unbounded.
module mux_share_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic       x,
  input  logic       y,
  output logic       sel,
  output logic [1:0] grant,
  output logic       m,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          own;
  logic          other;
  logic          release_own;
  logic          other_waits;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_nxt    = last;
    own         = (state == G1);
    other       = ~own;
    release_own = ~req[own] | done[own];
    other_waits = req[other];

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        case (req)
          2'b01:   state_nxt = G0;
          2'b10:   state_nxt = G1;
          2'b11:   state_nxt = last ? G0 : G1;
          default: state_nxt = IDLE;
        endcase
      end
      G0, G1: begin
        if (release_own || (cnt == CNT_MAX && other_waits)) begin
          // Hand over directly when someone waits, so there is no idle bubble.
          cnt_nxt   = '0;
          last_nxt  = own;
          state_nxt = other_waits ? (own ? G0 : G1) : IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      sel   <= 1'b0;
      m     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      // sel tracks the owner and holds its value through IDLE.
      if (state_nxt == G0)
        sel <= 1'b0;
      else if (state_nxt == G1)
        sel <= 1'b1;
      m <= (state == G0) ? x : (state == G1) ? y : 1'b0;
    end
  end

  assign grant = {state == G1, state == G0};
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Randomized and directed bench for mux_share_arbiter; a tenure-based reference model feeds a scoreboard queue.
module tb_mux_share_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req   = 2'b00;
  logic [1:0] done  = 2'b00;
  logic       x     = 1'b0;
  logic       y     = 1'b0;
  logic       sel;
  logic [1:0] grant;
  logic       m;
  logic       busy;

  mux_share_arbiter #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done), .x(x), .y(y),
    .sel(sel), .grant(grant), .m(m), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] grant;
    logic       sel;
    logic       m;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: owner index (-1 idle), cycles served in the current grant,
  // last owner, select and data bit.
  int owner  = -1;
  int tenure = 0;
  int last_o = 1;
  bit m_sel  = 0;
  bit m_dat  = 0;

  task automatic model(input logic rst, input logic [1:0] rq, input logic [1:0] dn,
                       input logic xx, input logic yy);
    exp_t e;
    int   oth;
    if (rst) begin
      owner = -1; tenure = 0; last_o = 1; m_sel = 0; m_dat = 0;
    end else begin
      m_dat = (owner == 0) ? xx : (owner == 1) ? yy : 1'b0;
      if (owner < 0) begin
        if (rq == 2'b11)  owner = 1 - last_o;
        else if (rq[0])   owner = 0;
        else if (rq[1])   owner = 1;
        if (owner >= 0) tenure = 1;
      end else begin
        oth = 1 - owner;
        if (!rq[owner] || dn[owner] || (tenure >= HOLD_MAX && rq[oth])) begin
          last_o = owner;
          if (rq[oth]) begin
            owner  = oth;
            tenure = 1;
          end else begin
            owner = -1;
          end
        end else begin
          tenure++;
        end
      end
      if (owner >= 0) m_sel = (owner == 1);
    end
    e.grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e.sel   = m_sel;
    e.m     = m_dat;
    e.busy  = (owner >= 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic [1:0] rq, input logic [1:0] dn,
                     input logic xx, input logic yy);
    @(negedge clock);
    reset = rst; req = rq; done = dn; x = xx; y = yy;
    model(rst, rq, dn, xx, yy);
  endtask

  // Monitor: one expected output set per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({grant, sel, m, busy} === e)
          n_pass++;
        else
          $display("FAIL outputs t=%0t got grant=%b sel=%b m=%b busy=%b want grant=%b sel=%b m=%b busy=%b",
                   $time, grant, sel, m, busy, e.grant, e.sel, e.m, e.busy);
      end
    end
  end

  initial begin
    logic [1:0] rq;
    logic [1:0] dn;
    // 1: reset then idle
    cyc(1, 2'b00, 2'b00, 0, 0);
    cyc(1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 2'b00, 2'b00, 1, 1);
    // 2: both requesting, preemption every HOLD_MAX cycles
    for (int i = 0; i < 20; i++) cyc(0, 2'b11, 2'b00, i[0], ~i[0]);
    cyc(0, 2'b00, 2'b00, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0);
    // 3: single requester, data follows x, then release
    cyc(0, 2'b01, 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 1, 0);
    cyc(0, 2'b01, 2'b00, 0, 0);
    cyc(0, 2'b01, 2'b00, 1, 0);
    cyc(0, 2'b00, 2'b00, 1, 0);
    cyc(0, 2'b00, 2'b00, 1, 0);
    // 4: early release by done with competitor, then done for non-owner
    cyc(0, 2'b01, 2'b00, 1, 1);
    cyc(0, 2'b01, 2'b00, 1, 1);
    cyc(0, 2'b11, 2'b01, 1, 1);
    cyc(0, 2'b11, 2'b00, 0, 1);
    cyc(0, 2'b11, 2'b01, 0, 0);
    cyc(0, 2'b11, 2'b00, 0, 1);
    cyc(0, 2'b00, 2'b00, 0, 0);
    // 5: long uncontested tenure, then immediate preemption
    for (int i = 0; i < 20; i++) cyc(0, 2'b01, 2'b00, i[1], 0);
    cyc(0, 2'b11, 2'b00, 1, 0);
    cyc(0, 2'b11, 2'b00, 1, 1);
    cyc(0, 2'b11, 2'b00, 0, 1);
    // 6: reset mid-G1 with both requesting
    for (int i = 0; i < 4; i++) cyc(0, 2'b11, 2'b00, 0, 1);
    cyc(1, 2'b11, 2'b00, 1, 1);
    cyc(0, 2'b11, 2'b00, 1, 1);
    cyc(0, 2'b11, 2'b00, 1, 1);
    // random traffic
    rq = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rq[0] = ~rq[0];
      if ($urandom_range(7) == 0) rq[1] = ~rq[1];
      dn[0] = ($urandom_range(9) == 0);
      dn[1] = ($urandom_range(9) == 0);
      cyc(($urandom_range(149) == 0), rq, dn, 1'($urandom), 1'($urandom));
    end
    @(negedge clock);
    @(negedge clock);
    n_chk++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: %0d expected outputs left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
